// File: rtl/game_pkg.sv
// Shared definitions for the factorization game: state codes decoded by the
// answer-input, question-display, 7-segment and judge blocks, plus counter widths.
package game_pkg;

   localparam int SCORE_W = 4;
   localparam int TIME_W  = 6;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'b0000,
      ST_LOAD     = 4'b0001,
      ST_QUESTION = 4'b0011,
      ST_INPUT    = 4'b0100,
      ST_JUDGE    = 4'b0101,
      ST_DRAW     = 4'b0110,
      ST_GOOD     = 4'b1000,
      ST_OUCH     = 4'b1001,
      ST_WIN      = 4'b1010,
      ST_LOSE     = 4'b1011
   } state_t;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == '1) ? v : v + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/game_sec_timer.sv
// One-second prescaler plus elapsed-second counter; done fires on the tick
// that completes load_val seconds. Both counters clear whenever clr is high.
module game_sec_timer
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clr,
   input  logic [TIME_W-1:0] load_val,
   output logic              sec_tick,
   output logic              done
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

   logic [PW-1:0]     presc_q;
   logic [TIME_W-1:0] sec_q;

   assign sec_tick = (presc_q == PW'(TICKS_PER_SEC - 1));
   assign done     = sec_tick && (sec_q == load_val - TIME_W'(1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         presc_q <= '0;
         sec_q   <= '0;
      end else if (clr) begin
         presc_q <= '0;
         sec_q   <= '0;
      end else if (sec_tick) begin
         presc_q <= '0;
         sec_q   <= sec_q + TIME_W'(1);
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

endmodule

// File: rtl/game_seq_ctrl.sv
// Round sequencer for the factorization game: question load, timed phases,
// judge handshake, score/miss keeping. GAME_STREAK_EN adds a streak bonus.
//
// state    | meaning
// IDLE     | waiting for START, counters held at 0
// LOAD     | Q_REQ high until the question store answers QUE_OK
// QUESTION | question shown for QUESTION_SEC seconds
// INPUT    | player answers; TIME_LEFT counts down
// JUDGE    | waiting for JUDGE_VALID
// DRAW     | input timed out (counts as miss)
// GOOD     | correct answer shown
// OUCH     | wrong answer shown
// WIN/LOSE | game over, counters frozen until START
module game_seq_ctrl
   import game_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int QUESTION_SEC  = 3,
   parameter int INPUT_SEC     = 30,
   parameter int RESULT_SEC    = 2,
   parameter int WIN_SCORE     = 5,
   parameter int MAX_MISS      = 3
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         START,
   input  logic         DEC,
   input  logic         QUE_OK,
   input  logic         JUDGE_VALID,
   input  logic         JUDGE_OK,
   output logic [3:0]   STATE,
   output logic         Q_REQ,
   output logic [3:0]   SCORE,
   output logic [3:0]   MISS,
   output logic [5:0]   TIME_LEFT,
   output logic [7:0]   ROUND
);

   state_t              state_q, state_d;
   logic                tmr_clr, sec_tick, tmr_done;
   logic [TIME_W-1:0]   tmr_load;
   logic [SCORE_W-1:0]  score_q, miss_q;
   logic [TIME_W-1:0]   time_left_q;
   logic [7:0]          round_q;
   logic                q_req_q;
`ifdef GAME_STREAK_EN
   logic [1:0]          streak_q;
`endif

   // Any state change restarts the timer so each timed state lasts whole seconds.
   assign tmr_clr = (state_d != state_q);

   game_sec_timer #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_sec_timer (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (tmr_clr),
      .load_val (tmr_load),
      .sec_tick (sec_tick),
      .done     (tmr_done)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tmr_load = TIME_W'(RESULT_SEC);
      case (state_q)
         ST_IDLE:     if (START) state_d = ST_LOAD;
         ST_LOAD:     if (QUE_OK) state_d = ST_QUESTION;
         ST_QUESTION: begin
            tmr_load = TIME_W'(QUESTION_SEC);
            if (tmr_done) state_d = ST_INPUT;
         end
         ST_INPUT: begin
            if (DEC)                                 state_d = ST_JUDGE;
            else if (sec_tick && time_left_q <= 1)   state_d = ST_DRAW;
         end
         ST_JUDGE:    if (JUDGE_VALID) state_d = JUDGE_OK ? ST_GOOD : ST_OUCH;
         ST_GOOD, ST_OUCH, ST_DRAW: begin
            if (tmr_done) begin
               if (score_q >= SCORE_W'(WIN_SCORE))     state_d = ST_WIN;
               else if (miss_q >= SCORE_W'(MAX_MISS))  state_d = ST_LOSE;
               else                                    state_d = ST_LOAD;
            end
         end
         ST_WIN, ST_LOSE: if (START) state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         q_req_q     <= 1'b0;
         score_q     <= '0;
         miss_q      <= '0;
         time_left_q <= '0;
         round_q     <= '0;
`ifdef GAME_STREAK_EN
         streak_q    <= '0;
`endif
      end else begin
         q_req_q <= (state_d == ST_LOAD);
         if (state_d == ST_IDLE) begin
            score_q  <= '0;
            miss_q   <= '0;
            round_q  <= '0;
`ifdef GAME_STREAK_EN
            streak_q <= '0;
`endif
         end else if (state_d != state_q) begin
            case (state_d)
               ST_LOAD:  if (round_q != 8'hFF) round_q <= round_q + 8'd1;
               ST_INPUT: time_left_q <= TIME_W'(INPUT_SEC);
               ST_GOOD: begin
                  score_q <= sat_inc(score_q);
`ifdef GAME_STREAK_EN
                  // A winning answer ends the game, so the bonus is not applied.
                  if (streak_q == 2'd2 && sat_inc(score_q) < SCORE_W'(WIN_SCORE)) begin
                     streak_q <= '0;
                     if (miss_q != '0) miss_q <= miss_q - SCORE_W'(1);
                  end else begin
                     streak_q <= streak_q + 2'd1;
                  end
`endif
               end
               ST_OUCH: begin
                  miss_q   <= sat_inc(miss_q);
`ifdef GAME_STREAK_EN
                  streak_q <= '0;
`endif
               end
               ST_DRAW: begin
                  miss_q      <= sat_inc(miss_q);
                  time_left_q <= '0;
`ifdef GAME_STREAK_EN
                  streak_q    <= '0;
`endif
               end
               default: ;
            endcase
         end else if (state_q == ST_INPUT && sec_tick) begin
            time_left_q <= time_left_q - TIME_W'(1);
         end
      end
   end

   assign STATE     = state_q;
   assign Q_REQ     = q_req_q;
   assign SCORE     = score_q;
   assign MISS      = miss_q;
   assign TIME_LEFT = time_left_q;
   assign ROUND     = round_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Scoreboard bench for game_seq_ctrl: expected state entries are queued as
// stimulus is driven and compared when STATE changes. Define GAME_STREAK_EN to cover the streak bonus.
module tb_game_seq_ctrl;
   import game_pkg::*;

   localparam int TPS = 4, QS = 1, IS = 3, RS = 1, MAX_P = 2;
`ifdef GAME_STREAK_EN
   localparam int WIN_P = 5;
`else
   localparam int WIN_P = 2;
`endif

   logic       CLK = 1'b0, RST = 1'b1;
   logic       START = 1'b0, DEC = 1'b0, QUE_OK = 1'b0, JUDGE_VALID = 1'b0, JUDGE_OK = 1'b0;
   logic [3:0] STATE, SCORE, MISS;
   logic       Q_REQ;
   logic [5:0] TIME_LEFT;
   logic [7:0] ROUND;

   int n_checks = 0, n_err = 0;
   int m_score = 0, m_miss = 0, m_round = 0, m_streak = 0;

   typedef struct {
      int st; int score; int miss; int round; int tl; int dur;
   } exp_t;
   exp_t exp_q[$];
   int prev_st = 0, run_cnt = 0;

   always #5 CLK = ~CLK;

   game_seq_ctrl #(
      .TICKS_PER_SEC(TPS), .QUESTION_SEC(QS), .INPUT_SEC(IS),
      .RESULT_SEC(RS), .WIN_SCORE(WIN_P), .MAX_MISS(MAX_P)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .DEC(DEC), .QUE_OK(QUE_OK),
      .JUDGE_VALID(JUDGE_VALID), .JUDGE_OK(JUDGE_OK), .STATE(STATE), .Q_REQ(Q_REQ),
      .SCORE(SCORE), .MISS(MISS), .TIME_LEFT(TIME_LEFT), .ROUND(ROUND)
   );

   task automatic check_val(input string tag, input int obs, input int expv);
      n_checks++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   task automatic push_exp(input int st, input int tl, input int dur);
      exp_t r;
      r.st = st; r.score = m_score; r.miss = m_miss; r.round = m_round; r.tl = tl; r.dur = dur;
      exp_q.push_back(r);
   endtask

   // Compare each observed state entry against the oldest queued expectation.
   always @(negedge CLK) begin : mon
      exp_t r;
      int   dur;
      if (int'(STATE) != prev_st) begin
         dur = run_cnt;
         run_cnt = 1;
         if (exp_q.size() == 0) begin
            check_val("unexpected_transition", int'(STATE), prev_st);
         end else begin
            r = exp_q.pop_front();
            check_val($sformatf("state_from_%0d", prev_st), int'(STATE), r.st);
            check_val($sformatf("score_st%0d", r.st), int'(SCORE), r.score);
            check_val($sformatf("miss_st%0d", r.st), int'(MISS), r.miss);
            check_val($sformatf("round_st%0d", r.st), int'(ROUND), r.round);
            check_val($sformatf("q_req_st%0d", r.st), int'(Q_REQ), int'(r.st == int'(ST_LOAD)));
            if (r.tl >= 0)  check_val($sformatf("time_left_st%0d", r.st), int'(TIME_LEFT), r.tl);
            if (r.dur >= 0) check_val($sformatf("dur_before_st%0d", r.st), dur, r.dur);
         end
         prev_st = int'(STATE);
      end else begin
         run_cnt++;
      end
   end

   task automatic tick_in(input logic s, input logic d, input logic q, input logic jv, input logic jo);
      START = s; DEC = d; QUE_OK = q; JUDGE_VALID = jv; JUDGE_OK = jo;
      @(posedge CLK); #1;
      START = 0; DEC = 0; QUE_OK = 0; JUDGE_VALID = 0; JUDGE_OK = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   task automatic wait_state(input int target);
      int n = 0;
      while (int'(STATE) != target && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      if (int'(STATE) != target) check_val("wait_timeout", int'(STATE), target);
   endtask

   task automatic push_next(output int nx);
      if (m_score >= WIN_P)      nx = int'(ST_WIN);
      else if (m_miss >= MAX_P)  nx = int'(ST_LOSE);
      else                       nx = int'(ST_LOAD);
      if (nx == int'(ST_LOAD) && m_round < 255) m_round++;
      push_exp(nx, -1, RS * TPS);
   endtask

   task automatic new_game();
      m_score = 0; m_miss = 0; m_round = 1; m_streak = 0;
      push_exp(int'(ST_LOAD), -1, -1);
      tick_in(1, 0, 0, 0, 0);
   endtask

   task automatic load_question(input int load_wait);
      wait_state(int'(ST_LOAD));
      push_exp(int'(ST_QUESTION), -1, load_wait + 1);
      push_exp(int'(ST_INPUT), IS, QS * TPS);
      idle(load_wait);
      tick_in(0, 0, 1, 0, 0);
      wait_state(int'(ST_INPUT));
   endtask

   // Called on the first JUDGE cycle; stray START/DEC/QUE_OK must be ignored.
   task automatic judge_result(input bit ok);
      int nx;
      tick_in(1, 1, 1, 0, 0);
      if (ok) begin
         if (m_score < 15) m_score++;
`ifdef GAME_STREAK_EN
         if (m_streak == 2 && m_score < WIN_P) begin
            m_streak = 0;
            if (m_miss > 0) m_miss--;
         end else begin
            m_streak++;
         end
`endif
      end else begin
         if (m_miss < 15) m_miss++;
         m_streak = 0;
      end
      push_exp(ok ? int'(ST_GOOD) : int'(ST_OUCH), -1, 2);
      push_next(nx);
      tick_in(0, 0, 0, 1, ok);
      wait_state(nx);
   endtask

   // kind: 0 = correct answer, 1 = wrong answer, 2 = timeout
   task automatic play_round(input int kind, input int load_wait);
      int nx;
      load_question(load_wait);
      if (kind == 2) begin
         if (m_miss < 15) m_miss++;
         m_streak = 0;
         push_exp(int'(ST_DRAW), 0, IS * TPS);
         push_next(nx);
         check_val("tl_first", int'(TIME_LEFT), 3);
         tick_in(0, 0, 0, 1, 1);
         idle(3);
         check_val("tl_second", int'(TIME_LEFT), 2);
         idle(4);
         check_val("tl_third", int'(TIME_LEFT), 1);
         wait_state(nx);
      end else begin
         push_exp(int'(ST_JUDGE), IS, 1);
         tick_in(0, 1, 0, 0, 0);
         judge_result(kind == 0);
      end
   endtask

   task automatic end_game();
      idle(3);
      check_val("frozen_score", int'(SCORE), m_score);
      check_val("frozen_miss", int'(MISS), m_miss);
      check_val("frozen_round", int'(ROUND), m_round);
      m_score = 0; m_miss = 0; m_round = 0; m_streak = 0;
      push_exp(int'(ST_IDLE), -1, 4);
      tick_in(1, 0, 0, 0, 0);
   endtask

   task automatic async_reset();
      m_score = 0; m_miss = 0; m_round = 0; m_streak = 0;
      push_exp(int'(ST_IDLE), 0, -1);
      #2; RST = 1'b1;
      #1;
      check_val("arst_state", int'(STATE), 0);
      check_val("arst_q_req", int'(Q_REQ), 0);
      check_val("arst_score", int'(SCORE), 0);
      check_val("arst_miss", int'(MISS), 0);
      check_val("arst_time_left", int'(TIME_LEFT), 0);
      check_val("arst_round", int'(ROUND), 0);
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      check_val("rst_state", int'(STATE), 0);
      check_val("rst_q_req", int'(Q_REQ), 0);
      check_val("rst_score", int'(SCORE), 0);
      check_val("rst_miss", int'(MISS), 0);
      check_val("rst_time_left", int'(TIME_LEFT), 0);
      check_val("rst_round", int'(ROUND), 0);

      new_game();
`ifdef GAME_STREAK_EN
      play_round(1, 4);
      play_round(0, 0);
      play_round(0, 0);
      play_round(0, 0);
      async_reset();
`else
      play_round(0, 4);
      play_round(0, 0);
      end_game();
`endif

      new_game();
      play_round(2, 0);
      play_round(1, 0);
      end_game();

      // DEC on the same edge as the final INPUT tick
      new_game();
      load_question(0);
      idle(11);
      push_exp(int'(ST_JUDGE), 1, IS * TPS);
      tick_in(0, 1, 0, 0, 0);
      judge_result(1'b0);

      // Asynchronous reset in the middle of INPUT
      load_question(0);
      idle(2);
      async_reset();
      idle(8);
      check_val("idle_hold_state", int'(STATE), 0);
      check_val("idle_hold_round", int'(ROUND), 0);
      new_game();
      idle(2);
      check_val("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
